// File: rtl/sort_check_control.sv
// Sort-check scan controller: edge-triggered start, datapath strobes, Moore
// result flags and a saturating count of CHECK cycles.
module sort_check_control #(
  parameter int unsigned MAX_CHECK = 32
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       go,
  input  logic       inversion_found,
  input  logic       end_of_array,
  input  logic       zero_length_array,
  output logic       load_input,
  output logic       load_index,
  output logic       select_index,
  output logic       busy,
  output logic       done,
  output logic       sorted,
  output logic       timeout,
  output logic [5:0] check_cycles
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_CHECK    = 3'd2,
    S_SORTED   = 3'd3,
    S_UNSORTED = 3'd4,
    S_TIMEOUT  = 3'd5
  } state_t;

  localparam logic [5:0] LAST_CHECK = 6'(MAX_CHECK - 1);
  localparam logic [5:0] CNT_MAX    = 6'd63;

  state_t     state_q, state_d;
  logic       go_q;
  logic [5:0] cnt_q, cnt_d;
  logic       start;

  assign start        = go & ~go_q;
  assign check_cycles = cnt_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      go_q    <= 1'b0;
      cnt_q   <= 6'd0;
    end else begin
      state_q <= state_d;
      go_q    <= go;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    load_input   = 1'b0;
    load_index   = 1'b0;
    select_index = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    sorted       = 1'b0;
    timeout      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          cnt_d   = 6'd0;
        end
      end

      S_LOAD: begin
        load_input = 1'b1;
        load_index = 1'b1;
        busy       = 1'b1;
        cnt_d      = 6'd0;
        state_d    = S_CHECK;
      end

      S_CHECK: begin
        load_index   = 1'b1;
        select_index = 1'b1;
        busy         = 1'b1;
        cnt_d        = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 6'd1;
        // End-of-array beats inversion: the pair past the last element is invalid.
        if (zero_length_array)       state_d = S_SORTED;
        else if (end_of_array)       state_d = S_SORTED;
        else if (inversion_found)    state_d = S_UNSORTED;
        else if (cnt_q == LAST_CHECK) state_d = S_TIMEOUT;
      end

      S_SORTED, S_UNSORTED, S_TIMEOUT: begin
        done    = 1'b1;
        sorted  = (state_q == S_SORTED);
        timeout = (state_q == S_TIMEOUT);
        if (start) begin
          state_d = S_LOAD;
          cnt_d   = 6'd0;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = 6'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_sort_check_control.sv
// Directed bench for sort_check_control; instance a uses MAX_CHECK=32,
// instance b uses MAX_CHECK=8 and shares all inputs.
module tb_sort_check_control;

  // Output vector order: {load_input, load_index, select_index, busy, done, sorted, timeout}
  localparam logic [6:0] O_IDLE     = 7'b0000000;
  localparam logic [6:0] O_LOAD     = 7'b1101000;
  localparam logic [6:0] O_CHECK    = 7'b0111000;
  localparam logic [6:0] O_SORTED   = 7'b0000110;
  localparam logic [6:0] O_UNSORTED = 7'b0000100;
  localparam logic [6:0] O_TIMEOUT  = 7'b0000101;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic go = 1'b0;
  logic inv = 1'b0;
  logic eoa = 1'b0;
  logic zla = 1'b0;

  logic li_a, lx_a, sel_a, busy_a, done_a, sorted_a, to_a;
  logic li_b, lx_b, sel_b, busy_b, done_b, sorted_b, to_b;
  logic [5:0] cnt_a, cnt_b;
  logic [6:0] out_a, out_b;

  int errors = 0;
  int checks = 0;

  assign out_a = {li_a, lx_a, sel_a, busy_a, done_a, sorted_a, to_a};
  assign out_b = {li_b, lx_b, sel_b, busy_b, done_b, sorted_b, to_b};

  always #5 clock = ~clock;

  sort_check_control #(.MAX_CHECK(32)) dut_a (
    .clock(clock), .reset(reset), .go(go),
    .inversion_found(inv), .end_of_array(eoa), .zero_length_array(zla),
    .load_input(li_a), .load_index(lx_a), .select_index(sel_a),
    .busy(busy_a), .done(done_a), .sorted(sorted_a), .timeout(to_a),
    .check_cycles(cnt_a)
  );

  sort_check_control #(.MAX_CHECK(8)) dut_b (
    .clock(clock), .reset(reset), .go(go),
    .inversion_found(inv), .end_of_array(eoa), .zero_length_array(zla),
    .load_input(li_b), .load_index(lx_b), .select_index(sel_b),
    .busy(busy_b), .done(done_b), .sorted(sorted_b), .timeout(to_b),
    .check_cycles(cnt_b)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    #1;
    checks++;
    if (out_a !== O_IDLE || cnt_a !== 6'd0) begin
      errors++;
      $display("FAIL reset_async: out=%b cnt=%0d, need out=%b cnt=0", out_a, cnt_a, O_IDLE);
    end
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (out_a !== O_IDLE || cnt_a !== 6'd0 || out_b !== O_IDLE || cnt_b !== 6'd0) begin
        errors++;
        $display("FAIL idle_cycle%0d: a=%b/%0d b=%b/%0d, need %b/0", i, out_a, cnt_a, out_b, cnt_b, O_IDLE);
      end
    end
  endtask

  task automatic test_sorted_len5();
    go = 1'b1;
    tick();
    checks++;
    if (out_a !== O_LOAD || cnt_a !== 6'd0) begin
      errors++;
      $display("FAIL s5_load: out=%b cnt=%0d, need out=%b cnt=0", out_a, cnt_a, O_LOAD);
    end
    for (int n = 1; n <= 5; n++) begin
      tick();
      checks++;
      if (out_a !== O_CHECK || cnt_a !== 6'(n - 1)) begin
        errors++;
        $display("FAIL s5_check%0d: out=%b cnt=%0d, need out=%b cnt=%0d", n, out_a, cnt_a, O_CHECK, n - 1);
      end
      eoa = (n == 5);
    end
    tick();
    eoa = 1'b0;
    go  = 1'b0;
    checks++;
    if (out_a !== O_SORTED || cnt_a !== 6'd5) begin
      errors++;
      $display("FAIL s5_result: out=%b cnt=%0d, need out=%b cnt=5", out_a, cnt_a, O_SORTED);
    end
    tick();
  endtask

  task automatic test_inversion();
    go = 1'b1;
    tick();
    for (int n = 1; n <= 4; n++) begin
      tick();
      inv = (n == 4);
    end
    tick();
    inv = 1'b0;
    go  = 1'b0;
    checks++;
    if (out_a !== O_UNSORTED || cnt_a !== 6'd4) begin
      errors++;
      $display("FAIL inv4_result: out=%b cnt=%0d, need out=%b cnt=4", out_a, cnt_a, O_UNSORTED);
    end
    tick();
  endtask

  task automatic test_zero_length();
    go = 1'b1;
    tick();
    tick();
    zla = 1'b1;
    inv = 1'b1;
    tick();
    zla = 1'b0;
    inv = 1'b0;
    go  = 1'b0;
    checks++;
    if (out_a !== O_SORTED || cnt_a !== 6'd1) begin
      errors++;
      $display("FAIL zero_len: out=%b cnt=%0d, need out=%b cnt=1", out_a, cnt_a, O_SORTED);
    end
    tick();
  endtask

  task automatic test_timeout();
    go = 1'b1;
    tick();
    for (int n = 1; n <= 8; n++) begin
      tick();
      checks++;
      if (out_b !== O_CHECK || cnt_b !== 6'(n - 1)) begin
        errors++;
        $display("FAIL to_check%0d: out=%b cnt=%0d, need out=%b cnt=%0d", n, out_b, cnt_b, O_CHECK, n - 1);
      end
    end
    tick();
    checks++;
    if (out_b !== O_TIMEOUT || cnt_b !== 6'd8) begin
      errors++;
      $display("FAIL to_result: out=%b cnt=%0d, need out=%b cnt=8", out_b, cnt_b, O_TIMEOUT);
    end
    checks++;
    if (out_a !== O_CHECK || cnt_a !== 6'd8) begin
      errors++;
      $display("FAIL to_max32_still_check: out=%b cnt=%0d, need out=%b cnt=8", out_a, cnt_a, O_CHECK);
    end
    eoa = 1'b1;
    tick();
    eoa = 1'b0;
    go  = 1'b0;
    checks++;
    if (out_a !== O_SORTED || cnt_a !== 6'd9 || out_b !== O_TIMEOUT || cnt_b !== 6'd8) begin
      errors++;
      $display("FAIL to_hold: a=%b/%0d b=%b/%0d, need a=%b/9 b=%b/8", out_a, cnt_a, out_b, cnt_b, O_SORTED, O_TIMEOUT);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    go = 1'b1;
    tick();
    tick();
    tick();
    inv = 1'b1;
    tick();
    inv = 1'b0;
    checks++;
    if (out_a !== O_UNSORTED || cnt_a !== 6'd2) begin
      errors++;
      $display("FAIL b2b_unsorted: out=%b cnt=%0d, need out=%b cnt=2", out_a, cnt_a, O_UNSORTED);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (out_a !== O_UNSORTED || cnt_a !== 6'd2) begin
        errors++;
        $display("FAIL b2b_held_go%0d: out=%b cnt=%0d, need out=%b cnt=2", i, out_a, cnt_a, O_UNSORTED);
      end
    end
    go = 1'b0;
    tick();
    go = 1'b1;
    tick();
    checks++;
    if (out_a !== O_LOAD || cnt_a !== 6'd0) begin
      errors++;
      $display("FAIL b2b_restart_load: out=%b cnt=%0d, need out=%b cnt=0", out_a, cnt_a, O_LOAD);
    end
    tick();
    go = 1'b0;
    tick();
    go = 1'b1;
    tick();
    checks++;
    if (out_a !== O_CHECK || cnt_a !== 6'd2) begin
      errors++;
      $display("FAIL b2b_go_in_check: out=%b cnt=%0d, need out=%b cnt=2", out_a, cnt_a, O_CHECK);
    end
    tick();
    eoa = 1'b1;
    tick();
    eoa = 1'b0;
    checks++;
    if (out_a !== O_SORTED || cnt_a !== 6'd4) begin
      errors++;
      $display("FAIL b2b_result: out=%b cnt=%0d, need out=%b cnt=4", out_a, cnt_a, O_SORTED);
    end
    tick();
    checks++;
    if (out_a !== O_SORTED || cnt_a !== 6'd4) begin
      errors++;
      $display("FAIL b2b_no_restart: out=%b cnt=%0d, need out=%b cnt=4", out_a, cnt_a, O_SORTED);
    end
  endtask

  task automatic test_reset_mid_scan();
    go = 1'b0;
    tick();
    go = 1'b1;
    tick();
    tick();
    tick();
    #2 reset = 1'b1;
    #1;
    checks++;
    if (out_a !== O_IDLE || cnt_a !== 6'd0) begin
      errors++;
      $display("FAIL reset_mid_scan: out=%b cnt=%0d, need out=%b cnt=0", out_a, cnt_a, O_IDLE);
    end
    tick();
    reset = 1'b0;
    go    = 1'b0;
    tick();
    checks++;
    if (out_a !== O_IDLE || cnt_a !== 6'd0) begin
      errors++;
      $display("FAIL reset_release_idle: out=%b cnt=%0d, need out=%b cnt=0", out_a, cnt_a, O_IDLE);
    end
    go = 1'b1;
    tick();
    checks++;
    if (out_a !== O_LOAD) begin
      errors++;
      $display("FAIL reset_then_start: out=%b, need out=%b", out_a, O_LOAD);
    end
  endtask

  initial begin
    test_reset();
    test_sorted_len5();
    test_inversion();
    test_zero_length();
    test_timeout();
    test_back_to_back();
    test_reset_mid_scan();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
